// File: rtl/rf_mp_bypass_pkg.sv
// Shared definitions for the multi-ported register file with write->read
// bypass, busy scoreboard and commit trace.
//   DEF_DW / DEF_AW : default data and address widths of the GPR file
//   REG_ZERO        : architectural zero register (never written, never busy)
//   trc_rec_t       : layout of one commit-trace record {pc, reg, data}
//   idx_width()     : width of a port index for n ports (at least 1 bit)
//   pc_of_wpc4()    : recover the instruction PC from its PC+4 (mod 2**32)
package rf_mp_bypass_pkg;

    localparam int DEF_DW   = 32;
    localparam int DEF_AW   = 5;
    localparam int REG_ZERO = 0;

    typedef struct packed {
        logic [31:0]        pc;
        logic [DEF_AW-1:0]  rg;
        logic [DEF_DW-1:0]  data;
    } trc_rec_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Plain unsigned subtraction: PC+4 of 0 maps back to 0xFFFFFFFC.
    function automatic logic [31:0] pc_of_wpc4(input logic [31:0] wpc4);
        return wpc4 - 32'd4;
    endfunction

endpackage

// File: rtl/rf_mp_bypass_if.sv
// Bus between the pipeline and the register file.
//   raddr/rdata/rbusy      : NR read ports (address in, data and busy out)
//   iss_valid/iss_reg      : destination register of the instruction issued
//   we/waddr/wdata/wpc4    : NW writeback ports
//   trc_valid/reg/data/pc  : NW registered commit-trace records
// master = pipeline side, slave = register file side.
interface rf_mp_bypass_if #(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int NR = 2,
    parameter int NW = 1
) ();
    logic [NR*AW-1:0] raddr;
    logic [NR*DW-1:0] rdata;
    logic [NR-1:0]    rbusy;
    logic             iss_valid;
    logic [AW-1:0]    iss_reg;
    logic [NW-1:0]    we;
    logic [NW*AW-1:0] waddr;
    logic [NW*DW-1:0] wdata;
    logic [NW*32-1:0] wpc4;
    logic [NW-1:0]    trc_valid;
    logic [NW*AW-1:0] trc_reg;
    logic [NW*DW-1:0] trc_data;
    logic [NW*32-1:0] trc_pc;

    modport master (
        output raddr, iss_valid, iss_reg, we, waddr, wdata, wpc4,
        input  rdata, rbusy, trc_valid, trc_reg, trc_data, trc_pc
    );

    modport slave (
        input  raddr, iss_valid, iss_reg, we, waddr, wdata, wpc4,
        output rdata, rbusy, trc_valid, trc_reg, trc_data, trc_pc
    );
endinterface

// File: rtl/rf_bypass_sel.sv
// Priority match of one read address against all write ports.
//   raddr  : read address of this port
//   we     : per-port write enables
//   waddr  : per-port write addresses, port j at [j*AW +: AW]
//   wdata  : per-port write data, port j at [j*DW +: DW]
//   hit    : some enabled port writes raddr (never for the zero register)
//   idx    : index of the winning (highest-numbered) port
//   data   : write data of the winning port
module rf_bypass_sel
    import rf_mp_bypass_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int NW = 1,
    parameter int IW = 1
) (
    input  logic [AW-1:0]    raddr,
    input  logic [NW-1:0]    we,
    input  logic [NW*AW-1:0] waddr,
    input  logic [NW*DW-1:0] wdata,
    output logic             hit,
    output logic [IW-1:0]    idx,
    output logic [DW-1:0]    data
);

    // Ascending scan: a later (higher) match overwrites an earlier one, so
    // the highest port index wins, mirroring the storage write order.
    always_comb begin
        hit  = 1'b0;
        idx  = '0;
        data = '0;
        for (int j = 0; j < NW; j++) begin
            if (we[j] && (waddr[j*AW +: AW] == raddr) && (raddr != AW'(REG_ZERO))) begin
                hit  = 1'b1;
                idx  = IW'(j);
                data = wdata[j*DW +: DW];
            end
        end
    end

endmodule

// File: rtl/rf_mp_bypass.sv
// Parametrised GPR file: NR combinational read ports with same-cycle
// write->read bypass, NW posedge write ports (highest port wins on a
// collision), a per-register busy scoreboard and registered commit trace.
//   clk   : clock, all state changes on posedge
//   reset : synchronous active-high; clears registers, busy bits and trace
//   rf    : slave side of rf_mp_bypass_if (read, issue, write, trace)
module rf_mp_bypass
    import rf_mp_bypass_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int AW = DEF_AW,
    parameter int NR = 2,
    parameter int NW = 1
) (
    input  logic          clk,
    input  logic          reset,
    rf_mp_bypass_if.slave rf
);

    localparam int DEPTH = 2 ** AW;
    localparam int IW    = idx_width(NW);

    logic [DW-1:0]    regs [DEPTH];
    logic [DEPTH-1:0] busy_reg;
    logic [DEPTH-1:0] busy_next;

    // ------------------------------------------------------------------
    // Storage. Register 0 is never written; reads of it are forced to 0.
    // Ascending port order makes the highest port win on a collision.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int j = 0; j < NW; j++) begin
                if (rf.we[j] && (rf.waddr[j*AW +: AW] != AW'(REG_ZERO))) begin
                    regs[rf.waddr[j*AW +: AW]] <= rf.wdata[j*DW +: DW];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Busy scoreboard: writebacks clear, issue sets afterwards so a new
    // producer supersedes a retiring one for the same register.
    // ------------------------------------------------------------------
    always_comb begin
        busy_next = busy_reg;
        for (int j = 0; j < NW; j++) begin
            if (rf.we[j]) begin
                busy_next[rf.waddr[j*AW +: AW]] = 1'b0;
            end
        end
        if (rf.iss_valid) begin
            busy_next[rf.iss_reg] = 1'b1;
        end
        busy_next[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    genvar gi;

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    for (gi = 0; gi < NR; gi++) begin : g_rd
        logic [AW-1:0] ra;
        logic          hit;
        logic [IW-1:0] idx;
        logic [DW-1:0] byp_data;
        logic          winner_we;

        assign ra = rf.raddr[gi*AW +: AW];

        rf_bypass_sel #(
            .DW (DW),
            .AW (AW),
            .NW (NW),
            .IW (IW)
        ) u_sel (
            .raddr (ra),
            .we    (rf.we),
            .waddr (rf.waddr),
            .wdata (rf.wdata),
            .hit   (hit),
            .idx   (idx),
            .data  (byp_data)
        );

        // Enable of the winning port; equals hit, but qualifies the busy
        // mask on exactly the port whose data is being forwarded.
        assign winner_we = |(rf.we & (NW'(1) << idx));

        assign rf.rdata[gi*DW +: DW] = (ra == AW'(REG_ZERO)) ? '0 :
                                       hit                   ? byp_data :
                                                               regs[ra];

        // Forwarded data is already valid, so it is never reported busy.
        assign rf.rbusy[gi] = busy_reg[ra] && !(hit && winner_we);
    end

    // ------------------------------------------------------------------
    // Commit trace: one flop group per write port. Shadowed writes still
    // trace; the payload holds when the port does not commit.
    // ------------------------------------------------------------------
    for (gi = 0; gi < NW; gi++) begin : g_trc
        logic          valid_reg;
        logic [AW-1:0] reg_reg;
        logic [DW-1:0] data_reg;
        logic [31:0]   pc_reg;
        logic          commit;

        assign commit = rf.we[gi] && (rf.waddr[gi*AW +: AW] != AW'(REG_ZERO));

        always_ff @(posedge clk) begin
            if (reset) begin
                valid_reg <= 1'b0;
                reg_reg   <= '0;
                data_reg  <= '0;
                pc_reg    <= '0;
            end else begin
                valid_reg <= commit;
                if (commit) begin
                    reg_reg  <= rf.waddr[gi*AW +: AW];
                    data_reg <= rf.wdata[gi*DW +: DW];
                    pc_reg   <= pc_of_wpc4(rf.wpc4[gi*32 +: 32]);
                end
            end
        end

        assign rf.trc_valid[gi]           = valid_reg;
        assign rf.trc_reg[gi*AW +: AW]    = reg_reg;
        assign rf.trc_data[gi*DW +: DW]   = data_reg;
        assign rf.trc_pc[gi*32 +: 32]     = pc_reg;
    end

endmodule
